// File: rtl/decoder_scan_nto2n.sv
// Registered SEL_W-to-2**SEL_W decoder with 74138-style enables and active-low one-hot outputs.
// Direct mode decodes a loaded index; scan mode walks every output with a programmable dwell.
module decoder_scan_nto2n #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 g1,
  input  logic                 g2a_n,
  input  logic                 g2b_n,
  input  logic                 mode,
  input  logic                 load,
  input  logic [SEL_W-1:0]     sel,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(1<<SEL_W)-1:0] y_n,
  output logic [SEL_W-1:0]     idx,
  output logic                 wrap
);

  localparam int N = 1 << SEL_W;

  // Operating state is a pure function of the enables and mode each cycle; it is not stored.
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t             state;
  logic               en;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] cnt_next;
  logic [SEL_W-1:0]   idx_next;
  logic               wrap_next;
  logic [N-1:0]       y_next;

  // State register: idx, step counter, outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx       <= '0;
      dwell_cnt <= '0;
      y_n       <= '1;
      wrap      <= 1'b0;
    end else begin
      idx       <= idx_next;
      dwell_cnt <= cnt_next;
      y_n       <= y_next;
      wrap      <= wrap_next;
    end
  end

  // State decode and next-state logic.
  always_comb begin
    en        = g1 & ~g2a_n & ~g2b_n;
    state     = ST_OFF;
    idx_next  = idx;
    cnt_next  = dwell_cnt;
    wrap_next = 1'b0;
    if (en) state = mode ? ST_SCAN : ST_DIRECT;

    if (load) begin
      // load wins over stepping in every state, including OFF
      idx_next = sel;
      cnt_next = '0;
    end else begin
      case (state)
        ST_OFF: begin
          idx_next = idx;
          cnt_next = dwell_cnt;
        end
        ST_DIRECT: begin
          cnt_next = '0;
        end
        ST_SCAN: begin
          // >= so a dwell shrunk below the running count ends the step right away
          if (dwell_cnt >= dwell) begin
            cnt_next  = '0;
            idx_next  = idx + 1'b1;
            wrap_next = &idx;
          end else begin
            cnt_next = dwell_cnt + 1'b1;
          end
        end
        default: begin
          idx_next = idx;
          cnt_next = dwell_cnt;
        end
      endcase
    end
  end

  // Output decode uses the index being written this edge so y_n and idx move together.
  always_comb begin
    y_next = '1;
    if (en) y_next[idx_next] = 1'b0;
  end

endmodule
